// File: rtl/gpio_irq.sv
// GPIO edge interrupt controller: per-bit rise/fall detection into a W1C STATUS
// register, masked by ENABLE into a single registered level interrupt.
module gpio_irq #(
   parameter int unsigned GpiWidth  = 8,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned RegAddr   = 12
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 device_req_i,
   input  logic [AddrWidth-1:0] device_addr_i,
   input  logic                 device_we_i,
   input  logic [3:0]           device_be_i,
   input  logic [DataWidth-1:0] device_wdata_i,
   output logic                 device_rvalid_o,
   output logic [DataWidth-1:0] device_rdata_o,
   input  logic [GpiWidth-1:0]  gp_i,
   output logic                 irq_o
);

   localparam logic [RegAddr-1:0] AddrStatus = RegAddr'(5'h00);
   localparam logic [RegAddr-1:0] AddrEnable = RegAddr'(5'h04);
   localparam logic [RegAddr-1:0] AddrRiseEn = RegAddr'(5'h08);
   localparam logic [RegAddr-1:0] AddrFallEn = RegAddr'(5'h0C);
   localparam logic [RegAddr-1:0] AddrTest   = RegAddr'(5'h10);

   // Expand the four byte enables into a per-bit write mask.
   function automatic logic [GpiWidth-1:0] byte_mask(input logic [3:0] be);
      logic [GpiWidth-1:0] m;
      for (int i = 0; i < int'(GpiWidth); i++) begin
         m[i] = be[i >> 3];
      end
      return m;
   endfunction

   logic [GpiWidth-1:0]  status_r, enable_r, rise_en_r, fall_en_r, gp_q_r;
   logic                 armed_r, irq_r, rvalid_r;
   logic [DataWidth-1:0] rdata_r;

   logic [RegAddr-1:0]   reg_addr_s;
   logic                 wr_s, rd_s;
   logic                 sel_status_s, sel_enable_s, sel_rise_s, sel_fall_s, sel_test_s;
   logic [GpiWidth-1:0]  wmask_s, wval_s, w1c_s, tset_s;
   logic [GpiWidth-1:0]  rise_s, fall_s, event_s, rdval_s;
   logic [GpiWidth-1:0]  status_next_s, enable_next_s, rise_en_next_s, fall_en_next_s;
   logic                 unused_s;

   assign reg_addr_s   = device_addr_i[RegAddr-1:0];
   assign unused_s     = ^{device_addr_i, device_wdata_i};
   assign wr_s         = device_req_i & device_we_i;
   assign rd_s         = device_req_i & ~device_we_i;
   assign sel_status_s = (reg_addr_s == AddrStatus);
   assign sel_enable_s = (reg_addr_s == AddrEnable);
   assign sel_rise_s   = (reg_addr_s == AddrRiseEn);
   assign sel_fall_s   = (reg_addr_s == AddrFallEn);
   assign sel_test_s   = (reg_addr_s == AddrTest);

   // Write masking, edge detection and next-state for all registers.
   always_comb begin
      wmask_s = byte_mask(device_be_i);
      wval_s  = device_wdata_i[GpiWidth-1:0] & wmask_s;
      w1c_s   = (wr_s & sel_status_s) ? wval_s : '0;
      tset_s  = (wr_s & sel_test_s)   ? wval_s : '0;

      rise_s  = gp_i & ~gp_q_r;
      fall_s  = ~gp_i & gp_q_r;
      event_s = armed_r ? ((rise_s & rise_en_r) | (fall_s & fall_en_r)) : '0;

      // Sets are OR-ed in after the clear so a simultaneous set wins.
      status_next_s  = (status_r & ~w1c_s) | event_s | tset_s;
      enable_next_s  = (wr_s & sel_enable_s) ? ((enable_r  & ~wmask_s) | wval_s) : enable_r;
      rise_en_next_s = (wr_s & sel_rise_s)   ? ((rise_en_r & ~wmask_s) | wval_s) : rise_en_r;
      fall_en_next_s = (wr_s & sel_fall_s)   ? ((fall_en_r & ~wmask_s) | wval_s) : fall_en_r;

      case (reg_addr_s)
         AddrStatus: rdval_s = status_r;
         AddrEnable: rdval_s = enable_r;
         AddrRiseEn: rdval_s = rise_en_r;
         AddrFallEn: rdval_s = fall_en_r;
         default:    rdval_s = '0;
      endcase
   end

   // State, interrupt and read-response registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         status_r  <= '0;
         enable_r  <= '0;
         rise_en_r <= '0;
         fall_en_r <= '0;
         gp_q_r    <= '0;
         armed_r   <= 1'b0;
         irq_r     <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= '0;
      end else begin
         status_r  <= status_next_s;
         enable_r  <= enable_next_s;
         rise_en_r <= rise_en_next_s;
         fall_en_r <= fall_en_next_s;
         gp_q_r    <= gp_i;
         armed_r   <= 1'b1;
         irq_r     <= |(status_r & enable_r);
         rvalid_r  <= rd_s;
         rdata_r   <= rd_s ? DataWidth'(rdval_s) : '0;
      end
   end

   assign device_rvalid_o = rvalid_r;
   assign device_rdata_o  = rdata_r;
   assign irq_o           = irq_r;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq with a per-cycle reference model and literal checks.
module tb_gpio_irq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        rvalid;
   logic [31:0] rdata;
   logic [7:0]  gp;
   logic        irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpio_irq #(
      .GpiWidth (8),
      .AddrWidth(32),
      .DataWidth(32),
      .RegAddr  (12)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .device_req_i   (req),
      .device_addr_i  (addr),
      .device_we_i    (we),
      .device_be_i    (be),
      .device_wdata_i (wdata),
      .device_rvalid_o(rvalid),
      .device_rdata_o (rdata),
      .gp_i           (gp),
      .irq_o          (irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: what the registers hold after each edge.
   logic [7:0]  m_status = 8'h00, m_enable = 8'h00, m_rise = 8'h00, m_fall = 8'h00, m_gpq = 8'h00;
   bit          m_armed = 1'b0, m_irq = 1'b0, m_rvalid = 1'b0, m_live = 1'b0;
   logic [31:0] m_rdata = 32'h0;

   task automatic model_step();
      logic [7:0] ev, w1c, tset, mask, wv, rdv;
      if (rst) begin
         m_status = 8'h00; m_enable = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
         m_gpq = 8'h00; m_armed = 1'b0; m_irq = 1'b0; m_rvalid = 1'b0;
         m_rdata = 32'h0; m_live = 1'b1;
      end else begin
         ev = 8'h00;
         for (int i = 0; i < 8; i++) begin
            if (m_armed && !m_gpq[i] && gp[i] && m_rise[i]) ev[i] = 1'b1;
            if (m_armed && m_gpq[i] && !gp[i] && m_fall[i]) ev[i] = 1'b1;
         end
         mask = be[0] ? 8'hFF : 8'h00;
         wv   = wdata[7:0] & mask;
         case (addr[11:0])
            12'h000: rdv = m_status;
            12'h004: rdv = m_enable;
            12'h008: rdv = m_rise;
            12'h00C: rdv = m_fall;
            default: rdv = 8'h00;
         endcase
         m_rvalid = req && !we;
         m_rdata  = m_rvalid ? {24'h0, rdv} : 32'h0;
         m_irq    = (m_status & m_enable) != 8'h00;
         w1c  = (req && we && addr[11:0] == 12'h000) ? wv : 8'h00;
         tset = (req && we && addr[11:0] == 12'h010) ? wv : 8'h00;
         m_status = (m_status & ~w1c) | ev | tset;
         if (req && we && addr[11:0] == 12'h004) m_enable = (m_enable & ~mask) | wv;
         if (req && we && addr[11:0] == 12'h008) m_rise   = (m_rise   & ~mask) | wv;
         if (req && we && addr[11:0] == 12'h00C) m_fall   = (m_fall   & ~mask) | wv;
         m_gpq   = gp;
         m_armed = 1'b1;
      end
   endtask

   // Advance the model on each edge and compare the DUT just after it.
   always @(posedge clk) begin
      model_step();
      #1;
      if (m_live) begin
         chk("model irq",    {31'h0, irq},    {31'h0, m_irq});
         chk("model rvalid", {31'h0, rvalid}, {31'h0, m_rvalid});
         chk("model rdata",  rdata,           m_rdata);
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
      @(negedge clk);
      req = 1'b0; we = 1'b0; wdata = 32'h0; be = 4'h0;
   endtask

   task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      req = 1'b0;
      chk({name, " rvalid"}, {31'h0, rvalid}, 32'h1);
      chk(name, rdata, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; gp = 8'h00;
      idle(3);
      chk("reset irq",    {31'h0, irq},    32'h0);
      chk("reset rvalid", {31'h0, rvalid}, 32'h0);
      chk("reset rdata",  rdata,           32'h0);
      rst = 1'b0;
      idle(2);
      rd_check("reset status", 32'h00, 32'h0);
      rd_check("reset enable", 32'h04, 32'h0);

      // Case 1: enabled rising edge on bit 0
      wr(32'h08, 32'h01, 4'hF);
      wr(32'h04, 32'h01, 4'hF);
      gp = 8'h01;
      idle(1);
      chk("c1 irq not yet", {31'h0, irq}, 32'h0);
      idle(1);
      chk("c1 irq high", {31'h0, irq}, 32'h1);
      rd_check("c1 status", 32'h00, 32'h1);
      wr(32'h00, 32'h01, 4'hF);
      chk("c1 irq still high", {31'h0, irq}, 32'h1);
      idle(1);
      chk("c1 irq cleared", {31'h0, irq}, 32'h0);

      // Case 2: falling edge latched while masked, lost edge while disabled
      wr(32'h0C, 32'h80, 4'hF);
      wr(32'h04, 32'h00, 4'hF);
      gp = 8'h81;
      idle(1);
      wr(32'h08, 32'h81, 4'hF);
      rd_check("c2 lost rise", 32'h00, 32'h0);
      gp = 8'h01;
      idle(2);
      chk("c2 irq masked", {31'h0, irq}, 32'h0);
      rd_check("c2 status", 32'h00, 32'h80);
      wr(32'h04, 32'h80, 4'hF);
      chk("c2 irq lag", {31'h0, irq}, 32'h0);
      idle(1);
      chk("c2 irq high", {31'h0, irq}, 32'h1);
      wr(32'h00, 32'h80, 4'hF);
      wr(32'h04, 32'h00, 4'hF);
      idle(1);

      // Case 3: set beats clear on the same bit
      gp = 8'h00;
      idle(1);
      wr(32'h10, 32'h03, 4'hF);
      rd_check("c3 preset", 32'h00, 32'h3);
      gp = 8'h01;
      wr(32'h00, 32'h01, 4'hF);
      rd_check("c3 set wins", 32'h00, 32'h3);
      wr(32'h00, 32'h01, 4'hF);
      rd_check("c3 cleared", 32'h00, 32'h2);
      wr(32'h00, 32'hFF, 4'hF);

      // Case 5: TEST write with byte enables, unmapped access
      wr(32'h04, 32'hFF, 4'hF);
      wr(32'h10, 32'h104, 4'b0001);
      idle(1);
      chk("c5 irq", {31'h0, irq}, 32'h1);
      rd_check("c5 status", 32'h00, 32'h4);
      rd_check("c5 test reads 0", 32'h10, 32'h0);
      rd_check("c5 unmapped", 32'h40, 32'h0);
      wr(32'h04, 32'h00, 4'b0000);
      rd_check("c5 be none", 32'h04, 32'hFF);
      wr(32'h40, 32'hFF, 4'hF);
      rd_check("c5 rise kept", 32'h08, 32'h81);

      // Case 6: reset right behind a read request
      req = 1'b1; we = 1'b0; addr = 32'h04;
      idle(1);
      req = 1'b0; rst = 1'b1;
      idle(1);
      chk("c6 rvalid dropped", {31'h0, rvalid}, 32'h0);
      chk("c6 irq dropped",    {31'h0, irq},    32'h0);
      rst = 1'b0;
      idle(2);
      rd_check("c6 status",  32'h00, 32'h0);
      rd_check("c6 enable",  32'h04, 32'h0);
      rd_check("c6 rise_en", 32'h08, 32'h0);
      rd_check("c6 fall_en", 32'h0C, 32'h0);

      // Case 4: inputs high through reset release
      gp = 8'hFF; rst = 1'b1;
      idle(2);
      rst = 1'b0;
      wr(32'h08, 32'hFF, 4'hF);
      wr(32'h04, 32'hFF, 4'hF);
      idle(2);
      chk("c4 irq", {31'h0, irq}, 32'h0);
      rd_check("c4 status", 32'h00, 32'h0);
      gp = 8'hFE;
      idle(1);
      gp = 8'hFF;
      idle(2);
      chk("c4 later irq", {31'h0, irq}, 32'h1);
      rd_check("c4 later status", 32'h00, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
